riscv_id_ex_stage: RTL
======================

Name: riscv_id_ex_stage

Overview:
- ID/EX pipeline register and EX-side operand network of the 5-stage RV32I core; sits directly upstream of riscv_alu.
- Captures decoded instructions from ID.
- Forwards results from EX/MEM and MEM/WB.
- Selects ALU operands and drives riscv_alu operand_a, operand_b and alu_op.
- Detects load-use hazards and inserts bubbles.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register addresses
- id_alu_op  in  4  ALU opcode, riscv_alu encoding 0-9
- id_alu_src_imm  in  1  ALU second operand is the immediate
- id_alu_src_pc  in  1  ALU first operand is the PC (AUIPC, JAL/JALR link)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- stall  in  1  downstream stall: hold all registers
- flush  in  1  kill the instruction being captured (branch/jump redirect)
- exmem_reg_write  in  1, exmem_rd_addr  in  5, exmem_result  in  32  EX/MEM forwarding source
- memwb_reg_write  in  1, memwb_rd_addr  in  5, memwb_result  in  32  MEM/WB forwarding source
- load_use_hazard  out  1  combinational; upstream must hold PC and IF/ID this cycle
- ex_valid  out  1  registered valid
- ex_pc  out  32  registered PC
- alu_operand_a, alu_operand_b  out  32 each  combinational, to riscv_alu
- alu_op  out  4  registered, to riscv_alu
- ex_store_data  out  32  forwarded rs2, for stores
- ex_rd_addr  out  5  registered
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered

Behaviour:
- Register update priority per clock edge:
  - rst: clear all registers to 0 (ex_valid=0, alu_op=0/ADD, all control=0, all data/addr=0).
  - else flush: load a bubble.
  - else stall: hold every register.
  - else load_use_hazard: load a bubble.
  - else: capture all id_* fields; ex_valid <= id_valid.
- Bubble: valid=0, all control bits=0, alu_op=0, data/address fields=0.
- If id_valid=0 on a capture, control bits are forced to 0.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((ex_rd_addr==id_rs1_addr) | (ex_rd_addr==id_rs2_addr)).
  - Output even during stall or flush; it only affects register loading when those are low.
  - A hazard produces exactly one bubble: the load moves to MEM, the dependent instruction is captured next cycle and takes MEM/WB forwarding.
- Forwarding, combinational from registered rs1/rs2 addresses; same rule for rs1 and rs2:
  - If exmem_reg_write & exmem_rd_addr!=0 & addresses match: use exmem_result.
  - Else if memwb_reg_write & memwb_rd_addr!=0 & addresses match: use memwb_result.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- ALU operand convention (fixed by riscv_alu: SUB computes operand_b - operand_a; shifts shift operand_b by operand_a[4:0]; SLT/SLTU give operand_b < operand_a):
  - alu_operand_b = ex_alu_src_pc ? ex_pc : fwd_rs1.
  - alu_operand_a = ex_alu_src_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of alu_src_imm.
- Latency: ID to EX is 1 cycle. Operand outputs follow forwarding inputs in the same cycle with no register.
- A mid-operation rst overrides stall and flush in that cycle; outputs are in reset values after the edge.

Test Plan:
1. Reset then capture: rst one cycle, then id ADD, rs1=x1 (5), rs2=x2 (7), no forwarding → next cycle ex_valid=1, alu_op=0, alu_operand_b=5, alu_operand_a=7.
2. Double forwarding: EX capture with rs1=x3; exmem rd=x3 result 0x11; memwb rd=x3 result 0x22 → alu_operand_b=0x11. Drop exmem_reg_write → 0x22. Repeat with rd=x0 → register-file value.
3. Load-use: EX holds LW x5 (mem_read=1); ID has ADD rs2=x5 → load_use_hazard=1; next cycle ex_valid=0, control=0. Following cycle the ADD is captured; with memwb rd=x5 result 0xAB, alu_operand_a=0xAB.
4. Stall vs flush: stall=1 for 3 cycles → all ex_* outputs constant. flush=1 with stall=1 → bubble loaded. rst=1 with flush=0, stall=1 → reset values.
5. Immediate/PC select: SUB rs1=10, rs2=3, src_imm=0 → operand_b=10, operand_a=3 (ALU gives 7). AUIPC pc=0x100, imm=0x2000 → operand_b=0x100, operand_a=0x2000. SW rs2 forwarded 0x55 with src_imm=1 → ex_store_data=0x55.

Source files
------------

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register and EX-side operand network for the 5-stage RV32I core.
// Captures decoded ID fields, detects load-use hazards, forwards results and drives riscv_alu operands.
module riscv_id_ex_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_alu_src_imm,
    input  logic                  id_alu_src_pc,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,

    input  logic                  stall,
    input  logic                  flush,

    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0]       memwb_result,

    output logic                  load_use_hazard,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       alu_operand_a,
    output logic [XLEN-1:0]       alu_operand_b,
    output logic [3:0]            alu_op,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg
);

    localparam int unsigned ALU_OP_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  alu_src_imm;
        logic                  alu_src_pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    ex_reg_t capture_c;

    logic [XLEN-1:0] fwd_rs1_c;
    logic [XLEN-1:0] fwd_rs2_c;

    // A load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid &&
                          ((ex_q.rd_addr == id_rs1_addr) || (ex_q.rd_addr == id_rs2_addr));
    end

    // Fields captured from ID; control is dropped for non-valid slots
    always_comb begin
        capture_c             = '0;
        capture_c.valid       = id_valid;
        capture_c.pc          = id_pc;
        capture_c.rs1_data    = id_rs1_data;
        capture_c.rs2_data    = id_rs2_data;
        capture_c.imm         = id_imm;
        capture_c.rs1_addr    = id_rs1_addr;
        capture_c.rs2_addr    = id_rs2_addr;
        capture_c.rd_addr     = id_rd_addr;
        capture_c.alu_op      = id_alu_op;
        capture_c.alu_src_imm = id_alu_src_imm;
        capture_c.alu_src_pc  = id_alu_src_pc;
        capture_c.reg_write   = id_valid && id_reg_write;
        capture_c.mem_read    = id_valid && id_mem_read;
        capture_c.mem_write   = id_valid && id_mem_write;
        capture_c.mem_to_reg  = id_valid && id_mem_to_reg;
    end

    // Next-state priority: flush, stall, hazard bubble, capture
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_hazard) begin
            ex_d = '0;
        end else begin
            ex_d = capture_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM wins over MEM/WB; x0 is never forwarded
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       rf_data
    );
        logic [XLEN-1:0] res;
        res = rf_data;
        if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == addr)) begin
            res = exmem_result;
        end else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == addr)) begin
            res = memwb_result;
        end
        return res;
    endfunction

    always_comb begin
        fwd_rs1_c = fwd_sel(ex_q.rs1_addr, ex_q.rs1_data);
        fwd_rs2_c = fwd_sel(ex_q.rs2_addr, ex_q.rs2_data);
    end

    // riscv_alu takes rs1/PC on operand_b and rs2/imm on operand_a
    always_comb begin
        alu_operand_b = ex_q.alu_src_pc  ? ex_q.pc  : fwd_rs1_c;
        alu_operand_a = ex_q.alu_src_imm ? ex_q.imm : fwd_rs2_c;
        ex_store_data = fwd_rs2_c;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign alu_op        = ex_q.alu_op;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule
